xor_keystream_decoder: RTL and testbench

Streaming 64-bit decoder that recovers plaintext from XOR-keystream-encoded packets. Each beat is XORed with a xorshift64 keystream that restarts from a loaded seed at every packet boundary. The block also reports a per-packet XOR checksum of the recovered plaintext. It sits on the card-to-host path, downstream of DRAM DMA reads, and undoes the encoding applied by the companion XOR encoder on the write path.

---
 rtl/xor_keystream_decoder_if.sv | 41 ++++
 rtl/xor_keystream_decoder.sv | 117 +++++++++++
 tb/tb_xor_keystream_decoder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_keystream_decoder_if.sv
// Stream/control bundle for xor_keystream_decoder.
//   master : side that drives encoded beats, seeds and m_ready (upstream DMA + sink)
//   slave  : the decoder itself
// Signals:
//   seed_i/seed_load          keystream seed and one-cycle load strobe
//   s_data/s_valid/s_last     encoded input beat, s_ready back-pressure
//   m_data/m_valid/m_last     plaintext output beat, m_ready from downstream
//   csum_o/csum_valid         per-packet XOR checksum and its update pulse
//   seed_err                  sticky rejected-seed flag
interface xor_keystream_decoder_if #(
  parameter int unsigned DATA_W = 64
) ();

  logic [DATA_W-1:0] seed_i;
  logic              seed_load;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  logic [DATA_W-1:0] csum_o;
  logic              csum_valid;
  logic              seed_err;

  modport master (
    output seed_i, seed_load, s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last, csum_o, csum_valid, seed_err
  );

  modport slave (
    input  seed_i, seed_load, s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last, csum_o, csum_valid, seed_err
  );

endinterface

// File: rtl/xor_keystream_decoder.sv
// Streaming XOR-keystream decoder. Each beat of a packet is XORed with a
// xorshift64 keystream that restarts from the loaded seed at every packet
// boundary; a per-packet XOR checksum of the recovered plaintext is reported.
// Ports:
//   clk  : single clock
//   rst  : asynchronous active-high reset
//   bus  : xor_keystream_decoder_if.slave (seed, input stream, output stream,
//          checksum, seed error flag)
// Output is a single register slice with 1-cycle latency; s_ready depends
// only on the slice state and m_ready, never on s_valid.
module xor_keystream_decoder #(
  parameter int unsigned DATA_W = 64
) (
  input logic                  clk,
  input logic                  rst,
  xor_keystream_decoder_if.slave bus
);

  typedef enum logic [1:0] {StUnseeded, StIdle, StActive} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] run_q;
  logic [DATA_W-1:0] m_data_q;
  logic              m_valid_q;
  logic              m_last_q;
  logic [DATA_W-1:0] csum_q;
  logic              csum_valid_q;
  logic              seed_err_q;

  logic              s_ready;
  logic              accept;
  logic [DATA_W-1:0] plain;
  logic              seed_ok;
  logic              seed_bad;

  // xorshift64 step; shifts are logical and truncate to the beat width.
  function automatic logic [DATA_W-1:0] ks_step(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  always_comb begin
    s_ready  = (state_q != StUnseeded) && (!m_valid_q || bus.m_ready);
    accept   = bus.s_valid && s_ready;
    plain    = bus.s_data ^ key_q;
    // A seed is only taken between packets and never as zero (xorshift
    // would lock up at zero).
    seed_ok  = bus.seed_load && (bus.seed_i != '0) && (state_q != StActive);
    seed_bad = bus.seed_load && !seed_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StUnseeded;
      seed_q       <= '0;
      key_q        <= '0;
      run_q        <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
      seed_err_q   <= 1'b0;
    end else begin
      csum_valid_q <= 1'b0;

      if (seed_bad) begin
        seed_err_q <= 1'b1;
      end

      if (accept) begin
        m_data_q  <= plain;
        m_last_q  <= bus.s_last;
        m_valid_q <= 1'b1;
        if (bus.s_last) begin
          csum_q       <= run_q ^ plain;
          csum_valid_q <= 1'b1;
          run_q        <= '0;
          key_q        <= seed_q;
        end else begin
          run_q <= run_q ^ plain;
          key_q <= ks_step(key_q);
        end
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
      end

      // A seed loaded alongside an accepted beat wins over the key update:
      // the current beat already used the old key, the next one starts fresh.
      if (seed_ok) begin
        seed_q <= bus.seed_i;
        key_q  <= bus.seed_i;
      end

      unique case (state_q)
        StUnseeded: if (seed_ok) state_q <= StIdle;
        StIdle:     if (accept && !bus.s_last) state_q <= StActive;
        StActive:   if (accept && bus.s_last) state_q <= StIdle;
        default:    state_q <= StUnseeded;
      endcase
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_last     = m_last_q;
  assign bus.csum_o     = csum_q;
  assign bus.csum_valid = csum_valid_q;
  assign bus.seed_err   = seed_err_q;

endmodule

// File: tb/tb_xor_keystream_decoder.sv
// Scoreboard bench for xor_keystream_decoder: expected plaintext beats and
// checksums are queued when a beat is accepted and compared as the DUT emits them.
module tb_xor_keystream_decoder;

  localparam int unsigned DataW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xor_keystream_decoder_if #(.DATA_W(DataW)) bus ();

  xor_keystream_decoder #(.DATA_W(DataW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t       exp_q[$];
  logic [63:0] csum_q[$];

  // Reference model state: 0 unseeded, 1 idle, 2 active
  int          mdl_state;
  logic [63:0] mdl_seed;
  logic [63:0] mdl_key;
  logic [63:0] mdl_run;
  logic        mdl_err;

  int          bp_cnt = 0;
  logic        hold_vld = 1'b0;
  logic [63:0] hold_data;
  logic        hold_last;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ks_next(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  task automatic mdl_reset();
    mdl_state = 0;
    mdl_seed  = '0;
    mdl_key   = '0;
    mdl_run   = '0;
    mdl_err   = 1'b0;
    exp_q.delete();
    csum_q.delete();
  endtask

  task automatic mdl_accept(input logic [63:0] d, input logic l);
    beat_t       b;
    logic [63:0] p;
    p      = d ^ mdl_key;
    b.data = p;
    b.last = l;
    exp_q.push_back(b);
    if (l) begin
      csum_q.push_back(mdl_run ^ p);
      mdl_run   = '0;
      mdl_key   = mdl_seed;
      mdl_state = 1;
    end else begin
      mdl_run   = mdl_run ^ p;
      mdl_key   = ks_next(mdl_key);
      mdl_state = 2;
    end
  endtask

  // Downstream back-pressure: bp_cnt cycles of m_ready=0, then 1.
  always @(negedge clk) begin
    if (bp_cnt > 0) begin
      bus.m_ready = 1'b0;
      bp_cnt--;
    end else begin
      bus.m_ready = 1'b1;
    end
  end

  // Output monitor, sampled mid-cycle after the drivers have settled.
  always @(negedge clk) begin
    beat_t       e;
    logic [63:0] c;
    #2;
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        check_eq("hold_data", bus.m_data, hold_data);
        check_eq("hold_last", {63'd0, bus.m_last}, {63'd0, hold_last});
      end
      hold_vld = 1'b0;
      if (bus.m_valid && !bus.m_ready) begin
        check_eq("s_ready_stall", {63'd0, bus.s_ready}, 64'd0);
        hold_vld  = 1'b1;
        hold_data = bus.m_data;
        hold_last = bus.m_last;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("m_data", bus.m_data, e.data);
          check_eq("m_last", {63'd0, bus.m_last}, {63'd0, e.last});
        end
      end
      if (bus.csum_valid) begin
        check_eq("csum_with_last", {63'd0, bus.m_valid && bus.m_last}, 64'd1);
        if (csum_q.size() == 0) begin
          check_eq("unexpected_csum", 64'd1, 64'd0);
        end else begin
          c = csum_q.pop_front();
          check_eq("csum_o", bus.csum_o, c);
        end
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic l);
    int budget;
    budget = 0;
    @(negedge clk);
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    forever begin
      #1;
      if (bus.s_ready) break;
      budget++;
      if (budget > 100) begin
        check_eq("s_ready_timeout", {63'd0, bus.s_ready}, 64'd1);
        bus.s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    mdl_accept(d, l);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic load_seed(input logic [63:0] s);
    @(negedge clk);
    bus.seed_i    = s;
    bus.seed_load = 1'b1;
    if (s != 64'd0 && mdl_state != 2) begin
      mdl_seed = s;
      mdl_key  = s;
      if (mdl_state == 0) mdl_state = 1;
    end else begin
      mdl_err = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.seed_load = 1'b0;
    check_eq("seed_err", {63'd0, bus.seed_err}, {63'd0, mdl_err});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_m_valid"}, {63'd0, bus.m_valid}, 64'd0);
    check_eq({tag, "_m_data"}, bus.m_data, 64'd0);
    check_eq({tag, "_m_last"}, {63'd0, bus.m_last}, 64'd0);
    check_eq({tag, "_csum_o"}, bus.csum_o, 64'd0);
    check_eq({tag, "_csum_valid"}, {63'd0, bus.csum_valid}, 64'd0);
    check_eq({tag, "_seed_err"}, {63'd0, bus.seed_err}, 64'd0);
    check_eq({tag, "_s_ready"}, {63'd0, bus.s_ready}, 64'd0);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || csum_q.size() != 0) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check_eq("drain_beats", 64'(exp_q.size()), 64'd0);
    check_eq("drain_csums", 64'(csum_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    mdl_reset();
    @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] pkt[4];
    int          len;

    bus.seed_i    = '0;
    bus.seed_load = 1'b0;
    bus.s_data    = '0;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.m_ready   = 1'b1;
    mdl_reset();

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Zero seed from UNSEEDED is rejected and the block stays unseeded.
    load_seed(64'd0);
    check_eq("unseeded_s_ready", {63'd0, bus.s_ready}, 64'd0);
    pulse_reset();

    // Two-beat packet decodes to zeros with seed 1.
    load_seed(64'd1);
    send_beat(64'h1, 1'b0);
    send_beat(64'h40822041, 1'b1);
    // Key restarts per packet.
    send_beat(64'hFF, 1'b1);
    send_beat(64'hFF, 1'b1);
    wait_drain();

    // 4-beat packet under 5 cycles of back-pressure, then unstalled.
    pkt[0] = 64'h0123456789ABCDEF;
    pkt[1] = 64'hFEDCBA9876543210;
    pkt[2] = 64'hA5A5A5A55A5A5A5A;
    pkt[3] = 64'h00000000FFFFFFFF;
    bp_cnt = 5;
    for (int i = 0; i < 4; i++) send_beat(pkt[i], (i == 3));
    wait_drain();
    for (int i = 0; i < 4; i++) send_beat(pkt[i], (i == 3));
    wait_drain();

    // Seed load in ACTIVE is rejected; the packet keeps the old key.
    send_beat(64'h1111, 1'b0);
    load_seed(64'd5);
    send_beat(64'h2222, 1'b0);
    send_beat(64'h3333, 1'b1);
    send_beat(64'h1, 1'b1);
    wait_drain();

    // New seed in IDLE, then random packets with random back-pressure.
    load_seed(64'hDEADBEEFCAFEF00D);
    for (int p = 0; p < 6; p++) begin
      len    = int'($urandom_range(1, 5));
      bp_cnt = int'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) send_beat({$urandom, $urandom}, (i == len - 1));
    end
    wait_drain();

    // Reset mid-packet, re-seed and decode again.
    send_beat(64'h1234, 1'b0);
    wait_drain();
    pulse_reset();
    load_seed(64'd1);
    send_beat(64'h1, 1'b1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
